dift_trap_ctrl: RTL
===================

Name: dift_trap_ctrl

Overview:
- Receives tag-check violations from the DIFT tag check unit in the ID stage and converts them into a trap request with a full handshake to the core controller.
- Latches the cause and the faulting PC for the handler, and squashes the offending instruction.
- Blocks further DIFT traps until software clears the event.
- Keeps a sticky overflow flag and a saturating violation counter for DIFT CSRs.

Parameters:
- CNT_WIDTH, 16, width of the saturating violation counter.
- PC_WIDTH, 32, width of the captured faulting PC.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  DIFT trap generation globally enabled (from TCCR)
- instr_valid_i  in  1  ID-stage instruction valid and not stalled this cycle
- trap_i  in  1  tag-check violation from the tag check unit (combinational, same cycle as instr)
- trap_type_i  in  3  dift_trap_t: NONE=0, EXEC=1, JALR=2, BRAN=3, STOR=4, LOAD=5
- pc_id_i  in  PC_WIDTH  PC of the ID-stage instruction
- trap_ack_i  in  1  controller has taken the trap (entered handler)
- clear_i  in  1  handler write to DIFT status CSR: end service
- cnt_clear_i  in  1  reset violation counter
- kill_o  out  1  squash current ID instruction (combinational)
- stall_o  out  1  hold ID stage while request is outstanding
- trap_req_o  out  1  trap request to controller
- trap_cause_o  out  3  latched dift_trap_t cause
- trap_pc_o  out  PC_WIDTH  latched faulting PC
- busy_o  out  1  state != IDLE
- overflow_o  out  1  sticky: violation seen while busy
- trap_cnt_o  out  CNT_WIDTH  number of accepted violations, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; cause=NONE; pc=0; counter=0; overflow=0. Reset mid-request drops the request immediately with no ack required.
- Accept condition: hit = trap_i & instr_valid_i & enable_i. trap_i=0 with a nonzero type is ignored.
- kill_o = hit whenever state is IDLE, or when SERVICE and clear_i are both active. kill_o is 0 otherwise.
- States:
  - IDLE: on hit, latch cause=trap_type_i and pc=pc_id_i, increment counter, go to REQ at the next edge.
  - REQ: trap_req_o=1 and stall_o=1. Hold cause and pc stable. On trap_ack_i=1, go to SERVICE. trap_req_o drops the cycle after the ack edge.
  - SERVICE: trap_req_o=0 and stall_o=0. A hit does not kill and sets overflow_o=1; the counter is unchanged. On clear_i=1, go to IDLE. clear_i together with a hit in the same cycle: capture the new trap and go directly to REQ, with no overflow.
- Latency: hit in cycle N gives trap_req_o=1 in cycle N+1. The minimum full loop is hit, then REQ, then ack, then SERVICE.
- trap_ack_i outside REQ is ignored. clear_i outside SERVICE is ignored.
- A hit while in REQ cannot occur because ID is stalled. If it does occur, it is treated like a hit in SERVICE: set overflow, no capture.
- Overflow clears only on clear_i or reset.
- Counter:
  - +1 per accepted hit (the IDLE hit or the clear+hit in SERVICE); saturates at all-ones.
  - cnt_clear_i sets it to 0 and has priority over a simultaneous increment.
- Cause and pc hold their values after clear_i until the next capture.
- enable_i=0 while in REQ or SERVICE does not abort the in-flight trap; it only blocks new hits.
- trap_i=1 with type NONE is a protocol violation. The RTL records it as given; the bench flags it.

Test Plan:
- Single STORE trap: IDLE, hit with type=4 and pc=0x0000_1A04 -> kill_o=1 in the same cycle; next cycle trap_req_o=1, cause=4, pc=0x1A04, cnt=1, stall_o=1; ack after 3 cycles -> req drops, busy_o=1; clear_i -> IDLE.
- Overflow: in SERVICE, hit with type=1 -> overflow_o=1, kill_o=0, cause stays 4, cnt stays 1; clear_i -> overflow_o=0, state IDLE.
- Clear+hit same cycle: in SERVICE, clear_i=1 with JALR hit (type=2) at pc=0x2000 -> next cycle REQ, cause=2, pc=0x2000, cnt=2, overflow_o=0.
- Gating: enable_i=0 or instr_valid_i=0 with trap_i=1 -> no kill, no req, cnt unchanged. Ack or clear pulses in IDLE -> no state change.
- Saturation: CNT_WIDTH=4, 17 accepted traps -> cnt=15. cnt_clear_i together with a hit -> cnt=0.
- Async reset in REQ: drop rst_n mid-cycle -> trap_req_o, stall_o and busy_o go to 0 immediately; cause=0, cnt=0; normal operation resumes after release.

Source files
------------

// File: rtl/dift_trap_ctrl_if.sv
// Trap request handshake between the DIFT trap controller (master) and the core controller (slave).
// trap_req rises the cycle after a captured violation and stays high until the edge that samples trap_ack=1.
// trap_cause and trap_pc are stable for the whole time trap_req is high.
interface dift_trap_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                trap_req;
  logic                trap_ack;
  logic [2:0]          trap_cause;
  logic [PC_WIDTH-1:0] trap_pc;

  modport master (output trap_req, output trap_cause, output trap_pc, input trap_ack);
  modport slave  (input trap_req, input trap_cause, input trap_pc, output trap_ack);
endinterface

// File: rtl/dift_trap_ctrl.sv
// Turns DIFT tag-check violations from ID into a handshaked trap request, latches cause/PC,
// blocks further traps until software clears the event, and keeps overflow/counter status.
module dift_trap_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int PC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 instr_valid_i,
  input  logic                 trap_i,
  input  logic [2:0]           trap_type_i,
  input  logic [PC_WIDTH-1:0]  pc_id_i,
  input  logic                 clear_i,
  input  logic                 cnt_clear_i,
  dift_trap_ctrl_if.master     ctrl,
  output logic                 kill_o,
  output logic                 stall_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic [CNT_WIDTH-1:0] trap_cnt_o,
  output logic [1:0]           dbg_state_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [2:0]           cause_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 ovf_q;

  logic hit;
  logic in_idle, in_req, in_svc;
  logic capture;
  logic ovf_set;
  logic svc_clear;

  assign hit       = trap_i & instr_valid_i & enable_i;
  assign in_idle   = (state_q == IDLE);
  assign in_req    = (state_q == REQ);
  assign in_svc    = (state_q == SERVICE);
  assign svc_clear = in_svc & clear_i;

  // A violation is only taken when the handler is free, or is being released this very cycle.
  assign capture = hit & (in_idle | svc_clear);
  assign ovf_set = hit & (in_req | (in_svc & ~clear_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = REQ;
      REQ:     if (ctrl.trap_ack) state_d = SERVICE;
      SERVICE: if (clear_i) state_d = capture ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= 3'd0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cause_q <= trap_type_i;
        pc_q    <= pc_id_i;
      end
      // Overflow is sticky until the handler ends service; a clear+hit re-arms cleanly.
      if (svc_clear) ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clear_i) begin
      cnt_q <= '0;
    end else if (capture && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign kill_o          = capture;
  assign stall_o         = in_req;
  assign busy_o          = ~in_idle;
  assign overflow_o      = ovf_q;
  assign trap_cnt_o      = cnt_q;
  assign dbg_state_o     = state_q;
  assign ctrl.trap_req   = in_req;
  assign ctrl.trap_cause = cause_q;
  assign ctrl.trap_pc    = pc_q;

endmodule
